// File: rtl/gemm_ctrl_if.sv
// gemm_ctrl_if: command and memory-port bundle for the GEMM loop sequencer.
//   master modport: the command issuer; drives cmd_*, observes ready/busy/done and memory ports.
//   slave modport:  gemm_ctrl itself; accepts cmd_*, drives cmd_ready, memory ports, busy, done.
//   cmd_*            loop command (counts, bases, outer/inner strides, reset-mode flag)
//   inp_*/wgt_*      read enable and address for the input and weight memories
//   acc_*            accumulator port (enable, write strobe, address, zero-data select)
interface gemm_ctrl_if #(
    parameter int unsigned INP_AW = 11,
    parameter int unsigned WGT_AW = 10,
    parameter int unsigned ACC_AW = 11,
    parameter int unsigned CNT_W  = 14
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_reset;
    logic [CNT_W-1:0]  cmd_out_cnt;
    logic [CNT_W-1:0]  cmd_in_cnt;
    logic [INP_AW-1:0] cmd_inp_base;
    logic [INP_AW-1:0] cmd_inp_fo;
    logic [INP_AW-1:0] cmd_inp_fi;
    logic [WGT_AW-1:0] cmd_wgt_base;
    logic [WGT_AW-1:0] cmd_wgt_fo;
    logic [WGT_AW-1:0] cmd_wgt_fi;
    logic [ACC_AW-1:0] cmd_acc_base;
    logic [ACC_AW-1:0] cmd_acc_fo;
    logic [ACC_AW-1:0] cmd_acc_fi;
    logic              inp_en;
    logic [INP_AW-1:0] inp_addr;
    logic              wgt_en;
    logic [WGT_AW-1:0] wgt_addr;
    logic              acc_en;
    logic              acc_we;
    logic [ACC_AW-1:0] acc_addr;
    logic              acc_zero;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_reset, cmd_out_cnt, cmd_in_cnt,
               cmd_inp_base, cmd_inp_fo, cmd_inp_fi,
               cmd_wgt_base, cmd_wgt_fo, cmd_wgt_fi,
               cmd_acc_base, cmd_acc_fo, cmd_acc_fi,
        input  cmd_ready, inp_en, inp_addr, wgt_en, wgt_addr,
               acc_en, acc_we, acc_addr, acc_zero, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_reset, cmd_out_cnt, cmd_in_cnt,
               cmd_inp_base, cmd_inp_fo, cmd_inp_fi,
               cmd_wgt_base, cmd_wgt_fo, cmd_wgt_fi,
               cmd_acc_base, cmd_acc_fo, cmd_acc_fi,
        output cmd_ready, inp_en, inp_addr, wgt_en, wgt_addr,
               acc_en, acc_we, acc_addr, acc_zero, busy, done
    );
endinterface

// File: rtl/gemm_ctrl.sv
// gemm_ctrl: walks an outer x inner GEMM micro-op loop, two cycles per iteration
// (READ: fetch input/weight/accumulator, EXEC: write result or zero back to the same entry).
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts a running command without done
//   bus    gemm_ctrl_if slave: command handshake, memory enables/addresses, busy/done
module gemm_ctrl #(
    parameter int unsigned INP_AW = 11,
    parameter int unsigned WGT_AW = 10,
    parameter int unsigned ACC_AW = 11,
    parameter int unsigned CNT_W  = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    gemm_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRead, StExec, StDone} state_e;

    state_e            state_q, state_d;
    logic              rst_mode_q, rst_mode_d;
    logic [CNT_W-1:0]  out_last_q, out_last_d, in_last_q, in_last_d;
    logic [CNT_W-1:0]  o_q, o_d, i_q, i_d;
    logic [INP_AW-1:0] inp_fo_q, inp_fo_d, inp_fi_q, inp_fi_d, inp_row_q, inp_row_d;
    logic [INP_AW-1:0] inp_addr_q, inp_addr_d;
    logic [WGT_AW-1:0] wgt_fo_q, wgt_fo_d, wgt_fi_q, wgt_fi_d, wgt_row_q, wgt_row_d;
    logic [WGT_AW-1:0] wgt_addr_q, wgt_addr_d;
    logic [ACC_AW-1:0] acc_fo_q, acc_fo_d, acc_fi_q, acc_fi_d, acc_row_q, acc_row_d;
    logic [ACC_AW-1:0] acc_addr_q, acc_addr_d;
    logic              last_i;

    assign last_i = (i_q == in_last_q);

    always_comb begin
        state_d    = state_q;
        rst_mode_d = rst_mode_q;
        out_last_d = out_last_q;
        in_last_d  = in_last_q;
        o_d        = o_q;
        i_d        = i_q;
        inp_fo_d   = inp_fo_q;
        inp_fi_d   = inp_fi_q;
        inp_row_d  = inp_row_q;
        inp_addr_d = inp_addr_q;
        wgt_fo_d   = wgt_fo_q;
        wgt_fi_d   = wgt_fi_q;
        wgt_row_d  = wgt_row_q;
        wgt_addr_d = wgt_addr_q;
        acc_fo_d   = acc_fo_q;
        acc_fi_d   = acc_fi_q;
        acc_row_d  = acc_row_q;
        acc_addr_d = acc_addr_q;

        bus.cmd_ready = 1'b0;
        bus.inp_en    = 1'b0;
        bus.wgt_en    = 1'b0;
        bus.acc_en    = 1'b0;
        bus.acc_we    = 1'b0;
        bus.acc_zero  = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    rst_mode_d = bus.cmd_reset;
                    out_last_d = bus.cmd_out_cnt - CNT_W'(1);
                    in_last_d  = bus.cmd_in_cnt - CNT_W'(1);
                    o_d        = '0;
                    i_d        = '0;
                    inp_fo_d   = bus.cmd_inp_fo;
                    inp_fi_d   = bus.cmd_inp_fi;
                    inp_row_d  = bus.cmd_inp_base;
                    inp_addr_d = bus.cmd_inp_base;
                    wgt_fo_d   = bus.cmd_wgt_fo;
                    wgt_fi_d   = bus.cmd_wgt_fi;
                    wgt_row_d  = bus.cmd_wgt_base;
                    wgt_addr_d = bus.cmd_wgt_base;
                    acc_fo_d   = bus.cmd_acc_fo;
                    acc_fi_d   = bus.cmd_acc_fi;
                    acc_row_d  = bus.cmd_acc_base;
                    acc_addr_d = bus.cmd_acc_base;
                    if (bus.cmd_out_cnt == '0 || bus.cmd_in_cnt == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                bus.acc_en = 1'b1;
                bus.inp_en = ~rst_mode_q;
                bus.wgt_en = ~rst_mode_q;
                state_d    = StExec;
            end
            StExec: begin
                bus.acc_en   = 1'b1;
                bus.acc_we   = 1'b1;
                bus.acc_zero = rst_mode_q;
                if (!last_i) begin
                    i_d        = i_q + CNT_W'(1);
                    inp_addr_d = inp_addr_q + inp_fi_q;
                    wgt_addr_d = wgt_addr_q + wgt_fi_q;
                    acc_addr_d = acc_addr_q + acc_fi_q;
                end else begin
                    // Inner wrap: step the row origin by the outer stride and restart from it.
                    i_d        = '0;
                    o_d        = o_q + CNT_W'(1);
                    inp_row_d  = inp_row_q + inp_fo_q;
                    inp_addr_d = inp_row_q + inp_fo_q;
                    wgt_row_d  = wgt_row_q + wgt_fo_q;
                    wgt_addr_d = wgt_row_q + wgt_fo_q;
                    acc_row_d  = acc_row_q + acc_fo_q;
                    acc_addr_d = acc_row_q + acc_fo_q;
                end
                state_d = (last_i && o_q == out_last_q) ? StDone : StRead;
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.inp_addr = inp_addr_q;
    assign bus.wgt_addr = wgt_addr_q;
    assign bus.acc_addr = acc_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rst_mode_q <= 1'b0;
            out_last_q <= '0;
            in_last_q  <= '0;
            o_q        <= '0;
            i_q        <= '0;
            inp_fo_q   <= '0;
            inp_fi_q   <= '0;
            inp_row_q  <= '0;
            inp_addr_q <= '0;
            wgt_fo_q   <= '0;
            wgt_fi_q   <= '0;
            wgt_row_q  <= '0;
            wgt_addr_q <= '0;
            acc_fo_q   <= '0;
            acc_fi_q   <= '0;
            acc_row_q  <= '0;
            acc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rst_mode_q <= rst_mode_d;
            out_last_q <= out_last_d;
            in_last_q  <= in_last_d;
            o_q        <= o_d;
            i_q        <= i_d;
            inp_fo_q   <= inp_fo_d;
            inp_fi_q   <= inp_fi_d;
            inp_row_q  <= inp_row_d;
            inp_addr_q <= inp_addr_d;
            wgt_fo_q   <= wgt_fo_d;
            wgt_fi_q   <= wgt_fi_d;
            wgt_row_q  <= wgt_row_d;
            wgt_addr_q <= wgt_addr_d;
            acc_fo_q   <= acc_fo_d;
            acc_fi_q   <= acc_fi_d;
            acc_row_q  <= acc_row_d;
            acc_addr_q <= acc_addr_d;
        end
    end
endmodule

// File: tb/tb_gemm_ctrl.sv
// tb_gemm_ctrl: directed bench for gemm_ctrl with a small memory + scalar gemm_op model.
//   Input memory word at address a is a+1, weight word is 2a+1, accumulator starts at 100+a.
module tb_gemm_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    gemm_ctrl_if bus ();

    gemm_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks    = 0;
    int n_err       = 0;
    int cyc         = 0;
    int last_accept = -1;
    int done_edge   = 0;
    int exp_inp[$];
    int exp_wgt[$];
    int exp_acc[$];

    // Memory model: one-cycle read latency, read-first accumulator port.
    int   acc_mem [2048];
    logic mem_init = 1'b0;
    int   inp_q    = 0;
    int   wgt_q    = 0;
    int   acc_rd   = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.cmd_valid && bus.cmd_ready) last_accept <= cyc + 1;
    end

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int j = 0; j < 2048; j++) acc_mem[j] <= 100 + j;
            mem_init <= 1'b1;
        end else begin
            if (bus.inp_en) inp_q <= int'(bus.inp_addr) + 1;
            if (bus.wgt_en) wgt_q <= 2 * int'(bus.wgt_addr) + 1;
            if (bus.acc_en) begin
                if (bus.acc_we) acc_mem[bus.acc_addr] <= bus.acc_zero ? 0 : acc_rd + inp_q * wgt_q;
                else            acc_rd <= acc_mem[bus.acc_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic send(input bit rm, input int oc, input int ic,
                        input int ib, input int ifo, input int ifi,
                        input int wb, input int wfo, input int wfi,
                        input int ab, input int afo, input int afi, input bit keep);
        @(negedge clk);
        bus.cmd_reset    = rm;
        bus.cmd_out_cnt  = 14'(oc);
        bus.cmd_in_cnt   = 14'(ic);
        bus.cmd_inp_base = 11'(ib);
        bus.cmd_inp_fo   = 11'(ifo);
        bus.cmd_inp_fi   = 11'(ifi);
        bus.cmd_wgt_base = 10'(wb);
        bus.cmd_wgt_fo   = 10'(wfo);
        bus.cmd_wgt_fi   = 10'(wfi);
        bus.cmd_acc_base = 11'(ab);
        bus.cmd_acc_fo   = 11'(afo);
        bus.cmd_acc_fi   = 11'(afi);
        bus.cmd_valid    = 1'b1;
        check("ready_before", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        if (!keep) bus.cmd_valid = 1'b0;
        check("accept", last_accept, cyc);
    endtask

    // Checks n READ/EXEC pairs against the expectation queues, then DONE and IDLE.
    task automatic run_loop(input bit rm, input int n);
        logic [6:0] e_rd, e_ex;
        e_rd = {1'b1, 1'b1, 1'b0, ~rm, ~rm, 1'b0, 1'b0};
        e_ex = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rm, 1'b0};
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("rd_ctl", {bus.busy, bus.acc_en, bus.acc_we, bus.inp_en, bus.wgt_en,
                             bus.acc_zero, bus.done}, e_rd);
            if (!rm) begin
                check("rd_inp", bus.inp_addr, exp_inp[k]);
                check("rd_wgt", bus.wgt_addr, exp_wgt[k]);
            end
            check("rd_acc", bus.acc_addr, exp_acc[k]);
            @(negedge clk);
            check("ex_ctl", {bus.busy, bus.acc_en, bus.acc_we, bus.inp_en, bus.wgt_en,
                             bus.acc_zero, bus.done}, e_ex);
            check("ex_acc", bus.acc_addr, exp_acc[k]);
        end
        @(negedge clk);
        check("done_ctl", {bus.busy, bus.done, bus.cmd_ready, bus.acc_en, bus.inp_en,
                           bus.wgt_en}, 6'b110000);
        done_edge = cyc;
        check("done_t", done_edge - last_accept, 2 * n);
        @(negedge clk);
        check("idle_ctl", {bus.busy, bus.done, bus.cmd_ready}, 3'b001);
    endtask

    initial begin
        bus.cmd_valid = 1'b1;
        bus.cmd_reset = 1'b0;
        bus.cmd_out_cnt = 14'd1;   bus.cmd_in_cnt = 14'd1;
        bus.cmd_inp_base = '0;     bus.cmd_inp_fo = '0;  bus.cmd_inp_fi = '0;
        bus.cmd_wgt_base = '0;     bus.cmd_wgt_fo = '0;  bus.cmd_wgt_fi = '0;
        bus.cmd_acc_base = '0;     bus.cmd_acc_fo = '0;  bus.cmd_acc_fi = '0;
        rst_n = 1'b0;

        // Reset held with cmd_valid high: idle outputs, nothing accepted.
        repeat (3) begin
            @(negedge clk);
            check("rst_ctl", {bus.cmd_ready, bus.busy, bus.done, bus.inp_en, bus.wgt_en,
                              bus.acc_en, bus.acc_we, bus.acc_zero}, 8'b1000_0000);
            check("rst_addr", {bus.inp_addr, bus.wgt_addr, bus.acc_addr}, 0);
        end
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;
        check("rst_no_accept", last_accept, -1);

        // Single iteration: acc[7] = 107 + 4*11.
        exp_inp = '{3}; exp_wgt = '{5}; exp_acc = '{7};
        send(0, 1, 1, 3, 0, 0, 5, 0, 0, 7, 0, 0, 0);
        run_loop(0, 1);
        check("acc7", acc_mem[7], 151);

        // 2x3 loop: acc[0] = 100+1+18+51, acc[2] = 102+17+162+323.
        exp_inp = '{0, 1, 2, 16, 17, 18};
        exp_wgt = '{0, 4, 8, 0, 4, 8};
        exp_acc = '{0, 0, 0, 2, 2, 2};
        send(0, 2, 3, 0, 16, 1, 0, 0, 4, 0, 2, 0, 0);
        run_loop(0, 6);
        check("acc0", acc_mem[0], 170);
        check("acc2", acc_mem[2], 604);

        // Reset mode zero-fills acc[10..13] only.
        exp_acc = '{10, 11, 12, 13};
        send(1, 1, 4, 0, 0, 0, 0, 0, 0, 10, 0, 1, 0);
        run_loop(1, 4);
        check("acc10", acc_mem[10], 0);
        check("acc13", acc_mem[13], 0);
        check("acc14", acc_mem[14], 114);

        // Zero outer count: done right after accept, no enables.
        send(0, 0, 5, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
        @(negedge clk);
        check("zero_done", {bus.busy, bus.done, bus.cmd_ready, bus.acc_en, bus.inp_en,
                            bus.wgt_en, bus.acc_we}, 7'b1100000);
        check("zero_t", cyc - last_accept, 0);
        @(negedge clk);
        check("zero_idle", {bus.busy, bus.done, bus.cmd_ready, bus.acc_en}, 4'b0010);

        // Accumulator address wraps 2047 -> 0; each iteration adds 1*1.
        exp_inp = '{0, 0}; exp_wgt = '{0, 0}; exp_acc = '{2047, 0};
        send(0, 1, 2, 0, 0, 0, 0, 0, 0, 2047, 0, 1, 0);
        run_loop(0, 2);
        check("acc2047", acc_mem[2047], 2148);
        check("acc0_wrap", acc_mem[0], 171);

        // Abort in EXEC of the second iteration: that write and all later ones are lost.
        send(0, 2, 2, 0, 0, 0, 0, 0, 0, 20, 1, 0, 0);
        repeat (4) @(negedge clk);
        check("abort_in_exec", {bus.acc_we, bus.acc_addr}, {1'b1, 11'd20});
        rst_n = 1'b0;
        #1;
        check("abort_ctl", {bus.busy, bus.done, bus.acc_en, bus.acc_we, bus.cmd_ready}, 5'b00001);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold", {bus.busy, bus.done, bus.acc_en, bus.acc_we}, 4'b0000);
        end
        rst_n = 1'b1;
        exp_inp = '{0}; exp_wgt = '{0}; exp_acc = '{40};
        send(0, 1, 1, 0, 0, 0, 0, 0, 0, 40, 0, 0, 0);
        run_loop(0, 1);
        check("acc20", acc_mem[20], 121);
        check("acc21", acc_mem[21], 121);
        check("acc40", acc_mem[40], 141);

        // Back-to-back with cmd_valid held: second accept two edges after done rises.
        exp_acc = '{30};
        send(0, 1, 1, 0, 0, 0, 0, 0, 0, 30, 0, 0, 1);
        run_loop(0, 1);
        @(posedge clk);
        #1;
        check("b2b_gap", last_accept - done_edge, 2);
        bus.cmd_valid = 1'b0;
        run_loop(0, 1);
        check("acc30", acc_mem[30], 132);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
